scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Scan sequencer that drives the 3-to-8 decoder stage: it walks through the enabled channels in ascending order and presents a 3-bit index plus enable. The decoder turns these into the one-hot channel strobe. Each channel is held for a programmable dwell time, followed by a fixed blanking gap with the enable low. Channels with a cleared mask bit are skipped, and a pulse marks each wrap of the scan.

## Interface
- DWELL_W, 8, width of the dwell-time input
- BLANK, 1, blanking cycles between channels; en low during blank; 0 = no gap

- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins scanning from IDLE
- stop  input  1  pulse; aborts scanning from any state
- mask  input  8  channel enable, bit i = channel i
- dwell  input  DWELL_W  cycles en is held per channel; 0 treated as 1
- sel  output  3  channel index to decoder `in`
- en  output  1  decoder enable
- busy  output  1  high in any state other than IDLE
- wrap  output  1  one-cycle pulse on scan wrap-around

## Operation
- States are IDLE, ACTIVE and BLANK. All outputs are registered.
- Reset, asynchronous:
  - state = IDLE; sel = 0; en = 0; busy = 0; wrap = 0; internal counters = 0.
- IDLE:
  - en = 0; sel holds its last value.
  - start with mask != 0: go to ACTIVE. sel = lowest set bit of mask, en = 1, busy = 1, wrap = 0.
  - start with mask == 0: ignored, stay in IDLE.
- ACTIVE:
  - dwell is sampled on entry; en = 1 for exactly max(dwell,1) cycles.
  - At the end of the dwell, go to BLANK if BLANK > 0. Otherwise advance directly.
- BLANK:
  - en = 0; sel holds; lasts exactly BLANK cycles, then advance.
- Advance:
  - Next channel = first set mask bit strictly above sel, searching modulo 8. The mask is sampled at the advance edge.
  - If the only set bit is sel, the same channel is reselected.
  - wrap = 1 in the first ACTIVE cycle when the new index <= the previous index. It never asserts on entry from IDLE.
  - If the sampled mask == 0, go to IDLE instead: en = 0, busy = 0.
- Mask changes during ACTIVE or BLANK never shorten the current dwell or blank. They affect only the next advance.
- stop:
  - From any state, the next edge gives IDLE, en = 0, busy = 0, wrap = 0; sel holds.
  - stop and start in the same cycle: stop wins.
- start while busy: ignored.

## Timing
- Start latency: start sampled at edge N gives en = 1 and a valid sel from edge N (visible in cycle N+1).
- Per-channel period = max(dwell,1) + BLANK cycles.
- sel changes only on the edge where en rises, or in the same edge as the advance when BLANK = 0. The decoder therefore never sees a sel change during a blank.
- BLANK = 0: en stays high continuously across channels; sel changes on the advance edge.
- Example, BLANK = 1, mask = 0000_0101, dwell = 3, start at edge 0:
  - cycles 1–3: sel = 0, en = 1
  - cycle 4: blank, en = 0
  - cycles 5–7: sel = 2, en = 1
  - cycle 8: blank
  - cycle 9: sel = 0, en = 1, wrap = 1
- Reset asserted mid-scan: outputs go to reset values immediately, without waiting for clk. After release, the block stays in IDLE until start.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n = 0 mid-ACTIVE on sel = 5.
  - Required: sel = 0, en = 0, busy = 0, wrap = 0 with no clock edge. After release, no activity without start.
- Basic scan:
  - Stimulus: BLANK = 1, mask = 0000_0101, dwell = 3, start pulse.
  - Required: exactly the cycle pattern in the Timing example; wrap high only in cycle 9.
- Full mask, dwell = 0:
  - Stimulus: BLANK = 1, mask = 1111_1111, dwell = 0.
  - Required: sel = 0..7, each with en high 1 cycle followed by 1 blank cycle. wrap on the return to 0; period 16 cycles.
- Single channel:
  - Stimulus: mask = 1000_0000, dwell = 2.
  - Required: sel stays 7; en pattern 1,1,0 repeating; wrap on every re-entry after the first.
- Mask edits:
  - Clear mask to 0 during BLANK after channel 3: next edge gives IDLE, busy = 0.
  - Clear bit 3 during ACTIVE on channel 3 with dwell = 4: en still high the full 4 cycles.
- Control collisions:
  - start and stop in the same cycle: remains IDLE.
  - stop during ACTIVE on sel = 6: next edge gives en = 0, busy = 0, sel = 6.
  - start with mask = 0: ignored.

Source files
------------

// File: rtl/scan_sequencer.sv
// ============================================================================
// scan_sequencer : walks enabled channels for a 3-to-8 decoder with dwell/blank
// Revision 1.0
// ============================================================================
`default_nettype none

module scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int BLANK   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               wrap
);

  localparam int         c_bw       = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [c_bw-1:0] c_blank_ld = c_bw'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_BLANK  = 2'd2
  } state_t;

  state_t              r_state;
  logic [2:0]          r_sel;
  logic                r_en;
  logic                r_busy;
  logic                r_wrap;
  logic [DWELL_W-1:0]  r_dcnt;
  logic [c_bw-1:0]     r_bcnt;

  logic [2:0]          w_next;
  logic [2:0]          w_first;
  logic                w_any;
  logic                w_adv;
  logic [DWELL_W-1:0]  w_dwell_ld;

  // First set bit strictly above cur, modulo 8; cur itself is the last candidate.
  function automatic logic [2:0] next_chan(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] idx;
    logic       found;
    next_chan = cur;
    found     = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = cur + 3'(k);
      if (!found && m[idx]) begin
        next_chan = idx;
        found     = 1'b1;
      end
    end
  endfunction

  always_comb begin
    w_any      = |mask;
    w_next     = next_chan(mask, r_sel);
    w_first    = next_chan(mask, 3'd7);
    w_dwell_ld = (dwell == '0) ? '0 : dwell - 1'b1;
    w_adv      = ((r_state == S_ACTIVE) && (r_dcnt == '0) && (BLANK == 0)) ||
                 ((r_state == S_BLANK)  && (r_bcnt == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 3'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_dcnt  <= '0;
      r_bcnt  <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_en    <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_adv) begin
        if (!w_any) begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end else begin
          // Wrap means the search went past channel 7 (or reselected itself).
          r_state <= S_ACTIVE;
          r_sel   <= w_next;
          r_en    <= 1'b1;
          r_wrap  <= (w_next <= r_sel);
          r_dcnt  <= w_dwell_ld;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && w_any) begin
              r_state <= S_ACTIVE;
              r_sel   <= w_first;
              r_en    <= 1'b1;
              r_busy  <= 1'b1;
              r_dcnt  <= w_dwell_ld;
            end
          end
          S_ACTIVE: begin
            if (r_dcnt != '0) begin
              r_dcnt <= r_dcnt - 1'b1;
            end else if (BLANK > 0) begin
              r_state <= S_BLANK;
              r_en    <= 1'b0;
              r_bcnt  <= c_blank_ld;
            end
          end
          S_BLANK: begin
            if (r_bcnt != '0) begin
              r_bcnt <= r_bcnt - 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel  = r_sel;
  assign en   = r_en;
  assign busy = r_busy;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_scan_sequencer.sv
// Scoreboarded bench for scan_sequencer: directed scenarios plus random traffic
// against a slot-arithmetic reference model.
`default_nettype none

module tb_scan_sequencer;

  localparam int DWELL_W = 8;
  localparam int BLANK   = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               en;
  logic               busy;
  logic               wrap;

  scan_sequencer #(.DWELL_W(DWELL_W), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .mask  (mask),
    .dwell (dwell),
    .sel   (sel),
    .en    (en),
    .busy  (busy),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] v;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_push = 0;

  // Reference model: position within the current channel slot of length len+BLANK.
  bit m_busy = 0;
  bit m_wrap = 0;
  int m_sel  = 0;
  int m_pos  = 0;
  int m_len  = 1;

  function automatic logic [5:0] outs();
    return {busy, en, wrap, sel};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got busy/en/wrap/sel=%b required %b at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  found;
    m_wrap = 0;
    if (stop) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (start && mask != 0) begin
        for (int i = 7; i >= 0; i--) if (mask[i]) m_sel = i;
        m_busy = 1;
        m_pos  = 0;
        m_len  = (dwell == 0) ? 1 : int'(dwell);
      end
    end else begin
      m_pos++;
      if (m_pos == m_len + BLANK) begin
        if (mask == 0) begin
          m_busy = 0;
        end else begin
          found = 0;
          nxt   = m_sel;
          for (int k = 1; k <= 8; k++) begin
            if (!found && mask[(m_sel + k) % 8]) begin
              nxt   = (m_sel + k) % 8;
              found = 1;
            end
          end
          m_wrap = (nxt <= m_sel);
          m_sel  = nxt;
          m_pos  = 0;
          m_len  = (dwell == 0) ? 1 : int'(dwell);
        end
      end
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    model_step();
    e.v   = {m_busy, (m_busy && (m_pos < m_len)), m_wrap, 3'(m_sel)};
    e.idx = n_push++;
    exp_q.push_back(e);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("scan[%0d]", e.idx), outs(), e.v);
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mask  = 8'h00;
    dwell = '0;
    #3;
    chk("reset_outputs", outs(), 6'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(3);

    // Async reset while channel 5 is active
    mask = 8'h20; dwell = 8'd20; start = 1'b1;
    run(4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_mid_active", outs(), 6'b0);
    exp_q.delete();
    m_busy = 0; m_sel = 0; m_wrap = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(5);

    // Basic scan: mask 0000_0101, dwell 3
    mask = 8'h05; dwell = 8'd3; start = 1'b1;
    run(20);
    stop = 1'b1; run(2);

    // Full mask, dwell 0
    mask = 8'hFF; dwell = 8'd0; start = 1'b1;
    run(36);
    stop = 1'b1; run(2);

    // Single channel 7, dwell 2
    mask = 8'h80; dwell = 8'd2; start = 1'b1;
    run(12);
    stop = 1'b1; run(2);

    // Clear bit 3 during its dwell: full dwell still served, then mask==0 returns to idle
    mask = 8'h08; dwell = 8'd4; start = 1'b1;
    run(2);
    mask = 8'h00;
    run(6);

    // Clear mask during the blank after channel 3
    mask = 8'h18; dwell = 8'd1; start = 1'b1;
    run(2);
    mask = 8'h00;
    run(4);

    // start with stop, start with empty mask, stop on channel 6
    mask = 8'h40; dwell = 8'd5; start = 1'b1; stop = 1'b1;
    run(3);
    mask = 8'h00; start = 1'b1;
    run(3);
    mask = 8'h40; start = 1'b1;
    run(3);
    stop = 1'b1;
    run(3);

    // Start while busy is ignored
    mask = 8'h03; dwell = 8'd2; start = 1'b1;
    run(3);
    start = 1'b1;
    run(8);
    stop = 1'b1; run(1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0)
        mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      dwell = DWELL_W'($urandom_range(0, 5));
      cyc();
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
